cond_flag_unit: RTL and testbench
=================================

// Module: cond_flag_unit
// PURPOSE
//  Consumer side of the ALU flag interface: holds the architectural NZCV flags written back by alu,
//  and evaluates each issued instruction's condition field against them. Sits between decode and
//  execute as a one-entry pipeline stage. Flag-setting instructions are tracked in flight, and any
//  conditional instruction stalls until the flags it depends on have been written back.
// PARAMETERS
//  MAX_PENDING  3  max flag-setting instructions in flight, i.e. issued but with flags not yet written back (>=1)
//  CNT_W        2  width of pending counter; must hold MAX_PENDING
// PORTS
//  clk         in   1   clock, all state updates on rising edge
//  rst_n       in   1   synchronous active-low reset
//  in_valid    in   1   decode presents an instruction
//  in_inst     in   32  instruction word (cond 31:28, opcode 24:21, S 20)
//  in_ready    out  1   stage accepts in_inst this cycle
//  out_valid   out  1   stage holds an instruction for execute
//  out_inst    out  32  held instruction word
//  out_exec    out  1   condition passed; execute may commit
//  out_ready   in   1   execute consumes the held instruction
//  flag_we     in   1   alu write-back strobe (alu update_CPSR qualified by execute)
//  flag_nzcv   in   4   {N,Z,C,V} from alu
//  flags       out  4   architectural NZCV register
//  err_underflow out 1  one-cycle pulse: flag_we seen with pending==0 and no same-cycle issue
// BEHAVIOUR
//  Reset: flags=0, pending=0, out_valid=0, out_inst=0, out_exec=0, err_underflow=0. in_ready is combinational.
//  Flag-setting (fs) = opcode in {TST,TEQ,CMP,CMN} or S bit set; opcode is the 4-bit field 24:21.
//  flags_fwd = flag_we ? flag_nzcv : flags. flags <= flags_fwd every cycle.
//  Condition: EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z;
//   GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1; NV(1111) 0.
//  Handshake: accept = in_valid & in_ready. Stage frees when !out_valid or (out_ready).
//  in_ready = stage_free & !dep_stall & !full_stall, where
//   dep_stall  = cond(in_inst)!=AL & (pending_next_nofwd>0 | (out_valid & fs(out_inst) & out_exec)),
//   pending_next_nofwd = pending - flag_we (flags still owed after this cycle's write-back),
//   full_stall = fs(in_inst) & pending==MAX_PENDING.
//  On accept: out_inst<=in_inst, out_valid<=1, out_exec<=cond(in_inst, flags_fwd). Latency 1 cycle.
//  While held (out_valid & !out_ready): out_exec re-evaluated each cycle with flags_fwd.
//  Handoff (out_valid & out_ready & !accept): out_valid<=0, out_exec<=0.
//  Pending: inc when out_valid & out_ready & out_exec & fs(out_inst); dec on flag_we.
//   Inc and dec same cycle -> unchanged. flag_we at pending==0 with no inc -> counter stays 0,
//   flags still written, err_underflow=1 next cycle. Counter never exceeds MAX_PENDING.
//  Failed-condition fs instructions never increment (they write no flags).
//  Reset mid-operation: held instruction dropped, pending cleared, flags cleared.
// STRUCTURE
//  Opcode (`TST/`TEQ/`CMP/`CMN), field bit positions, and 4-bit condition codes (`COND_EQ..`COND_NV)
//  live in shared arm_constants.v; add field macros there, not locally.
//  One sub-module: cond_check (cond[3:0], nzcv[3:0] -> pass), combinational, reused by branch logic.
// TESTING
//  Reset, flags=0: issue 0xE0810002 (AL ADD) -> out_valid=1 and out_exec=1 next cycle; flags stay 0000.
//  flags=0100, issue 0x0A000000 (EQ B) -> out_exec=1; issue 0x1A000000 (NE) -> out_exec=0.
//  Issue 0xE1500001 (CMP); handoff with out_ready=1 -> pending=1. Then 0x0A000000 stalls
//   (in_ready=0) until flag_we=1, nzcv=0100; accepted that cycle -> out_exec=1 via forwarding.
//  Hold 0xB0000000 (LT) with out_ready=0, flags 0000; flag_we with nzcv=1000 -> out_exec 0->1.
//  Three AL ADDS handed off, no write-back -> pending=3; a 4th ADDS has in_ready=0; AL MOV still
//   accepted; one flag_we -> ADDS accepted.
//  flag_we with pending=0 -> err_underflow pulses 1 cycle, flags updated; rst_n=0 mid-hold -> all cleared.

Source files
------------

// File: rtl/cond_flag_unit_pkg.sv
// Shared instruction-field constants and helpers for the NZCV condition stage.
// Condition codes, flag-setting opcodes and word bit positions live here.
package cond_flag_unit_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1,
    COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5,
    COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9,
    COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD,
    COND_AL = 4'hE, COND_NV = 4'hF
  } cond_e;

  localparam logic [3:0] OP_TST = 4'h8;
  localparam logic [3:0] OP_TEQ = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_CMN = 4'hB;

  localparam int COND_HI_B = 31;
  localparam int COND_LO_B = 28;
  localparam int OP_HI_B   = 24;
  localparam int OP_LO_B   = 21;
  localparam int S_B       = 20;

  function automatic logic is_fs(
    input logic [3:0] op,
    input logic       s
  );
    return s | (op == OP_TST) | (op == OP_TEQ) |
           (op == OP_CMP) | (op == OP_CMN);
  endfunction

endpackage

// File: rtl/cond_flag_unit_cond_check.sv
// Combinational condition-code evaluator against {N,Z,C,V}.
// Shared with branch resolution.
module cond_check
  import cond_flag_unit_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;
  assign {n, z, c, v} = nzcv;

  always_comb begin
    pass = 1'b0;
    unique case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c & !z;
      COND_LS: pass = !c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_flag_unit.sv
// One-entry decode->execute stage holding NZCV and evaluating conditions,
// stalling conditional instructions while flag writers are in flight.
module cond_flag_unit
  import cond_flag_unit_pkg::*;
#(
  parameter int MAX_PENDING = 3,
  parameter int CNT_W       = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] in_inst,
  output logic        in_ready,
  output logic        out_valid,
  output logic [31:0] out_inst,
  output logic        out_exec,
  input  logic        out_ready,
  input  logic        flag_we,
  input  logic [3:0]  flag_nzcv,
  output logic [3:0]  flags,
  output logic        err_underflow
);

  localparam logic [CNT_W-1:0] PMAX = CNT_W'(MAX_PENDING);

  logic [3:0]       flags_q, flags_d, flags_fwd;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             ov_q, ov_d;
  logic [31:0]      oi_q, oi_d;
  logic             oe_q, oe_d;
  logic             err_q, err_d;

  logic in_pass, held_pass, in_fs, held_fs;
  logic stage_free, dep_stall, full_stall;
  logic accept, inc, owed;

  assign flags_fwd = flag_we ? flag_nzcv : flags_q;

  cond_check u_in_cc (
    .cond (in_inst[COND_HI_B:COND_LO_B]),
    .nzcv (flags_fwd),
    .pass (in_pass)
  );

  cond_check u_held_cc (
    .cond (oi_q[COND_HI_B:COND_LO_B]),
    .nzcv (flags_fwd),
    .pass (held_pass)
  );

  assign in_fs   = is_fs(in_inst[OP_HI_B:OP_LO_B], in_inst[S_B]);
  assign held_fs = is_fs(oi_q[OP_HI_B:OP_LO_B], oi_q[S_B]);

  // Flags still owed once this cycle's write-back lands
  assign owed = pend_q > {{(CNT_W-1){1'b0}}, flag_we};

  assign stage_free = !ov_q | out_ready;
  assign dep_stall  = (in_inst[COND_HI_B:COND_LO_B] != COND_AL) &
                      (owed | (ov_q & held_fs & oe_q));
  assign full_stall = in_fs & (pend_q == PMAX);
  assign in_ready   = stage_free & !dep_stall & !full_stall;
  assign accept     = in_valid & in_ready;
  assign inc        = ov_q & out_ready & oe_q & held_fs;

  always_comb begin
    ov_d    = ov_q;
    oi_d    = oi_q;
    oe_d    = oe_q;
    flags_d = flags_fwd;
    pend_d  = pend_q;
    err_d   = flag_we & !inc & (pend_q == '0);
    if (accept) begin
      ov_d = 1'b1;
      oi_d = in_inst;
      oe_d = in_pass;
    end else if (ov_q & !out_ready) begin
      oe_d = held_pass;
    end else if (ov_q & out_ready) begin
      ov_d = 1'b0;
      oe_d = 1'b0;
    end
    unique case ({inc, flag_we})
      2'b10:   if (pend_q != PMAX) pend_d = pend_q + 1'b1;
      2'b01:   if (pend_q != '0)   pend_d = pend_q - 1'b1;
      default: pend_d = pend_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_q <= '0;
      pend_q  <= '0;
      ov_q    <= 1'b0;
      oi_q    <= '0;
      oe_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      pend_q  <= pend_d;
      ov_q    <= ov_d;
      oi_q    <= oi_d;
      oe_q    <= oe_d;
      err_q   <= err_d;
    end
  end

  assign out_valid     = ov_q;
  assign out_inst      = oi_q;
  assign out_exec      = oe_q;
  assign flags         = flags_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_cond_flag_unit.sv
// Directed bench for cond_flag_unit: condition table plus
// hand-written stall, forwarding, hold, full and underflow sequences.
module tb_cond_flag_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_inst;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_inst;
  logic        out_exec;
  logic        out_ready;
  logic        flag_we;
  logic [3:0]  flag_nzcv;
  logic [3:0]  flags;
  logic        err_underflow;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  cond_flag_unit #(.MAX_PENDING(3), .CNT_W(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_inst       (in_inst),
    .in_ready      (in_ready),
    .out_valid     (out_valid),
    .out_inst      (out_inst),
    .out_exec      (out_exec),
    .out_ready     (out_ready),
    .flag_we       (flag_we),
    .flag_nzcv     (flag_nzcv),
    .flags         (flags),
    .err_underflow (err_underflow)
  );

  typedef struct {
    logic [3:0] nzcv;
    logic [3:0] cond;
    logic       exp;
  } vec_t;

  vec_t tbl[19];

  localparam logic [31:0] ADD  = 32'hE0810002;
  localparam logic [31:0] ADDS = 32'hE0910002;
  localparam logic [31:0] CMP  = 32'hE1500001;
  localparam logic [31:0] MOV  = 32'hE1A00001;
  localparam logic [31:0] BEQ  = 32'h0A000000;
  localparam logic [31:0] BLT  = 32'hB0000000;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{4'b0100, 4'h0, 1'b1};
    tbl[1]  = '{4'b0100, 4'h1, 1'b0};
    tbl[2]  = '{4'b0010, 4'h2, 1'b1};
    tbl[3]  = '{4'b0000, 4'h3, 1'b1};
    tbl[4]  = '{4'b1000, 4'h4, 1'b1};
    tbl[5]  = '{4'b1000, 4'h5, 1'b0};
    tbl[6]  = '{4'b0001, 4'h6, 1'b1};
    tbl[7]  = '{4'b0001, 4'h7, 1'b0};
    tbl[8]  = '{4'b0010, 4'h8, 1'b1};
    tbl[9]  = '{4'b0110, 4'h8, 1'b0};
    tbl[10] = '{4'b0110, 4'h9, 1'b1};
    tbl[11] = '{4'b1001, 4'hA, 1'b1};
    tbl[12] = '{4'b1000, 4'hA, 1'b0};
    tbl[13] = '{4'b1000, 4'hB, 1'b1};
    tbl[14] = '{4'b0000, 4'hC, 1'b1};
    tbl[15] = '{4'b0100, 4'hC, 1'b0};
    tbl[16] = '{4'b1000, 4'hD, 1'b1};
    tbl[17] = '{4'b0000, 4'hE, 1'b1};
    tbl[18] = '{4'b0000, 4'hF, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; in_inst = '0;
    out_ready = 1'b1; flag_we = 1'b0; flag_nzcv = '0;
    step(); step();
    chk("rst_flags", 32'(flags), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_inst", out_inst, 32'h0);
    chk("rst_exec", 32'(out_exec), 32'h0);
    chk("rst_err", 32'(err_underflow), 32'h0);
    rst_n = 1'b1;

    in_valid = 1'b1; in_inst = ADD;
    step();
    chk("add_valid", 32'(out_valid), 32'h1);
    chk("add_exec", 32'(out_exec), 32'h1);
    chk("add_inst", out_inst, ADD);
    chk("add_flags", 32'(flags), 32'h0);

    for (int i = 0; i < 19; i++) begin
      in_valid = 1'b1;
      in_inst = {tbl[i].cond, 28'hA000000};
      flag_we = 1'b1; flag_nzcv = tbl[i].nzcv;
      step();
      chk($sformatf("tbl%0d_exec", i), 32'(out_exec), 32'(tbl[i].exp));
      chk($sformatf("tbl%0d_flags", i), 32'(flags), 32'(tbl[i].nzcv));
    end
    flag_we = 1'b0;

    in_valid = 1'b1; in_inst = CMP;
    step();
    chk("cmp_exec", 32'(out_exec), 32'h1);
    in_inst = BEQ; #1;
    chk("dep_held_stall", 32'(in_ready), 32'h0);
    step();
    chk("dep_pend_stall", 32'(in_ready), 32'h0);
    flag_we = 1'b1; flag_nzcv = 4'b0100; #1;
    chk("dep_release", 32'(in_ready), 32'h1);
    step();
    chk("fwd_exec", 32'(out_exec), 32'h1);
    chk("fwd_inst", out_inst, BEQ);
    chk("fwd_flags", 32'(flags), 32'h4);
    chk("fwd_no_err", 32'(err_underflow), 32'h0);

    in_inst = BLT; flag_nzcv = 4'b0000;
    step();
    chk("lt_exec0", 32'(out_exec), 32'h0);
    in_valid = 1'b0; out_ready = 1'b0; flag_we = 1'b0;
    step();
    chk("lt_hold0", 32'(out_exec), 32'h0);
    flag_we = 1'b1; flag_nzcv = 4'b1000;
    step();
    chk("lt_hold1", 32'(out_exec), 32'h1);
    chk("lt_held_valid", 32'(out_valid), 32'h1);
    flag_we = 1'b0; out_ready = 1'b1;
    step();
    chk("lt_handoff", 32'(out_valid), 32'h0);

    in_valid = 1'b1; in_inst = ADDS;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("adds%0d_valid", i), 32'(out_valid), 32'h1);
    end
    in_valid = 1'b0;
    step();
    in_valid = 1'b1; #1;
    chk("full_stall", 32'(in_ready), 32'h0);
    in_inst = MOV; #1;
    chk("full_mov_ready", 32'(in_ready), 32'h1);
    step();
    chk("full_mov_inst", out_inst, MOV);
    in_valid = 1'b0; flag_we = 1'b1; flag_nzcv = 4'b0000;
    step();
    flag_we = 1'b0; in_valid = 1'b1; in_inst = ADDS; #1;
    chk("full_release", 32'(in_ready), 32'h1);
    step();
    chk("full_adds_inst", out_inst, ADDS);

    in_valid = 1'b0; out_ready = 1'b0;
    step();
    chk("hold_before_rst", 32'(out_valid), 32'h1);
    rst_n = 1'b0;
    step();
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_inst", out_inst, 32'h0);
    chk("mid_rst_exec", 32'(out_exec), 32'h0);
    rst_n = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; in_inst = BEQ; #1;
    chk("mid_rst_pend_clr", 32'(in_ready), 32'h1);
    step();
    in_valid = 1'b0;

    flag_we = 1'b1; flag_nzcv = 4'b1010;
    step();
    chk("uf_err", 32'(err_underflow), 32'h1);
    chk("uf_flags", 32'(flags), 32'hA);
    flag_we = 1'b0;
    step();
    chk("uf_pulse_end", 32'(err_underflow), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
